// File: rtl/sgpr_wr_port_arbiter_pkg.sv
// Shared constants and types for the SGPR write-port arbiter and its round-robin picker.
package sgpr_wr_port_arbiter_pkg;

  localparam int NUM_SGPR_WR_PORTS = 10;
  localparam int SGPR_WR_SEL_W     = 16;
  localparam int SGPR_PORT_SALU    = 9;
  localparam int SGPR_BEAT_W       = 2;
  localparam int SGPR_PTR_W        = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } sgpr_arb_state_e;

  function automatic logic [SGPR_PTR_W-1:0] sgpr_next_port(input logic [SGPR_PTR_W-1:0] p);
    return (p == SGPR_PTR_W'(NUM_SGPR_WR_PORTS - 1)) ? '0 : p + SGPR_PTR_W'(1);
  endfunction

endpackage

// File: rtl/sgpr_rr_pick.sv
// Combinational rotate-priority encoder: optional fixed-priority port, else first
// requester at or above rr_ptr_i, wrapping from N-1 back to 0.
module sgpr_rr_pick #(
  parameter int N         = 10,
  parameter int PTR_W     = 4,
  parameter int PRIO_PORT = 9
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] rr_ptr_i,
  input  logic             prio_en_i,
  output logic [PTR_W-1:0] winner_o,
  output logic             valid_o
);

  always_comb begin
    int               sum;
    logic [PTR_W-1:0] idx;
    winner_o = '0;
    valid_o  = 1'b0;
    sum      = 0;
    idx      = '0;
    if (prio_en_i && req_i[PRIO_PORT]) begin
      winner_o = PTR_W'(PRIO_PORT);
      valid_o  = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        sum = int'(rr_ptr_i) + k;
        if (sum >= N) sum = sum - N;
        idx = PTR_W'(sum);
        if (!valid_o && req_i[idx]) begin
          winner_o = idx;
          valid_o  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sgpr_wr_port_arbiter.sv
// Round-robin arbiter (optional SALU strict priority) driving the one-hot SGPR write-port
// select; holds each grant for a latched beat count and re-arbitrates back-to-back.
module sgpr_wr_port_arbiter
  import sgpr_wr_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = NUM_SGPR_WR_PORTS,
  parameter int SEL_W     = SGPR_WR_SEL_W,
  parameter int BEAT_W    = SGPR_BEAT_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS*BEAT_W-1:0] req_beats,
  input  logic                        salu_prio_en,
  output logic [SEL_W-1:0]            wr_port_select,
  output logic [NUM_PORTS-1:0]        grant_ack,
  output logic [NUM_PORTS-1:0]        grant_done,
  output logic                        drop_err,
  output logic                        busy
);

  localparam int PTR_W = SGPR_PTR_W;

  sgpr_arb_state_e      state_q, state_d;
  logic [PTR_W-1:0]     owner_q, owner_d, rr_q, rr_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [NUM_PORTS-1:0] done_q, done_d;
  logic                 drop_q, drop_d;

  logic [PTR_W-1:0]     owner_nxt, pick_ptr, pick_win;
  logic [NUM_PORTS-1:0] pick_req;
  logic                 pick_vld;
  logic [BEAT_W-1:0]    beats_arr [NUM_PORTS];

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) beats_arr[i] = req_beats[i*BEAT_W +: BEAT_W];
  end

  // On the last beat the owner is masked out and the search starts just past it,
  // which is exactly the rr_ptr value being written this cycle.
  assign owner_nxt = sgpr_next_port(owner_q);
  assign pick_req  = (state_q == ST_GRANT) ? (req & ~(NUM_PORTS'(1) << owner_q)) : req;
  assign pick_ptr  = (state_q == ST_GRANT) ? owner_nxt : rr_q;

  sgpr_rr_pick #(
    .N         (NUM_PORTS),
    .PTR_W     (PTR_W),
    .PRIO_PORT (SGPR_PORT_SALU)
  ) u_pick (
    .req_i     (pick_req),
    .rr_ptr_i  (pick_ptr),
    .prio_en_i (salu_prio_en),
    .winner_o  (pick_win),
    .valid_o   (pick_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
      sel_q   <= '0;
      done_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    beat_d  = beat_q;
    drop_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_GRANT;
          owner_d = pick_win;
          beat_d  = beats_arr[pick_win];
        end
      end
      ST_GRANT: begin
        if (beat_q != '0) begin
          if (!req[owner_q]) begin
            state_d = ST_IDLE;
            drop_d  = 1'b1;
            rr_d    = owner_nxt;
          end else begin
            beat_d = beat_q - BEAT_W'(1);
          end
        end else begin
          rr_d = owner_nxt;
          if (pick_vld) begin
            owner_d = pick_win;
            beat_d  = beats_arr[pick_win];
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Done is registered so it lands on the same cycle the final beat is visible.
  always_comb begin
    sel_d  = '0;
    done_d = '0;
    if (state_d == ST_GRANT) begin
      sel_d = SEL_W'(1) << owner_d;
      if (beat_d == '0) done_d = NUM_PORTS'(1) << owner_d;
    end
  end

  assign wr_port_select = sel_q;
  assign grant_ack      = sel_q[NUM_PORTS-1:0];
  assign grant_done     = done_q;
  assign drop_err       = drop_q;
  assign busy           = (state_q == ST_GRANT);

endmodule

// File: doc/sgpr_wr_port_arbiter.md
Name: sgpr_wr_port_arbiter

Overview:
Arbitrates the ten SGPR write sources (VALU/SALU/LSU/SIMX issue paths, ports 0-9) onto the single muxed SGPR write port. It generates the one-hot 16-bit wr_port_select that drives the SGPR write-port mux, using round-robin fairness and optional strict priority for the SALU port (9). Multi-beat writes are supported: a grant is held for a latched beat count.

Parameters:
NUM_PORTS, 10, number of requesters; fixed at 10 for this build
SEL_W, 16, width of wr_port_select; bits NUM_PORTS..SEL_W-1 are tied 0
BEAT_W, 2, width of per-port beat-count field (1..4 beats per grant)

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
req  input  NUM_PORTS  per-port write request; held high until the done pulse
req_beats  input  NUM_PORTS*BEAT_W  per-port beats minus 1; field i = bits [i*BEAT_W +: BEAT_W]; sampled at grant
salu_prio_en  input  1  1 = port 9 wins over round-robin when requesting
wr_port_select  output  SEL_W  registered one-hot select to the SGPR write mux; 0 = no write
grant_ack  output  NUM_PORTS  registered; bit i high on every cycle port i owns the mux (equals wr_port_select[NUM_PORTS-1:0])
grant_done  output  NUM_PORTS  registered one-cycle pulse on port i's last beat
drop_err  output  1  one-cycle pulse when an owner drops req mid-burst
busy  output  1  high while in GRANT

Behaviour:
- Reset (async assert, sync-free release): wr_port_select=0, grant_ack=0, grant_done=0, drop_err=0, busy=0, rr_ptr=0, beat_cnt=0, state=IDLE. Assert mid-burst clears the select immediately with no completion pulse.
- States: IDLE, GRANT.
- Arbitration (combinational on the current req, evaluated in IDLE or on the last beat of GRANT):
  - if salu_prio_en and req[9]: winner = 9
  - else winner = first set req bit searching upward from rr_ptr, wrapping 9 -> 0
- IDLE: if any req, next cycle state=GRANT, wr_port_select=onehot(winner), beat_cnt=req_beats[winner]. Latency req-to-select is 1 cycle. Otherwise remain IDLE with select 0.
- GRANT, beat_cnt != 0: hold select, beat_cnt-=1.
- GRANT, beat_cnt == 0 (last beat): grant_done[owner] pulses this cycle; rr_ptr <= (owner+1) mod 10. Re-arbitrate the same cycle, excluding owner's req (the owner must drop req after done). If there is another winner, the next cycle grants it back-to-back with no bubble; otherwise go to IDLE with select 0 next cycle.
- An owner whose req is low during GRANT causes an abort: drop_err pulses the next cycle, select=0, state=IDLE, no grant_done pulse, and rr_ptr advances past the owner.
- Requests arriving mid-burst wait. A new req has no effect until the arbitration point.
- Invariant: wr_port_select is one-hot or zero. Bits 15:10 are always 0. It never changes during a burst except through abort or reset.
- SALU priority can starve the others. This is accepted when salu_prio_en=1, and rr_ptr is still updated after the port-9 grant.

Decomposition:
- Shared package/defines header: NUM_SGPR_WR_PORTS=10, SGPR_WR_SEL_W=16, SGPR_PORT_SALU=9, and IDLE/GRANT state encodings.
- Sub-module: sgpr_rr_pick. It is a combinational rotate-priority encoder (req, rr_ptr, prio_en -> winner index + valid), reusable by the VGPR arbiter.

Test Plan:
- Reset, then req=0x001 with beats0=0 -> wr_port_select=0x0001 one cycle after req, grant_done[0] pulses in the same cycle, select=0x0000 the cycle after.
- req=0x00C (ports 2,3), beats=0, rr_ptr=0 -> select 0x0004 then 0x0008 back-to-back with no bubble; rr_ptr ends at 4.
- Port 5 with beats5=3 -> 0x0020 held 4 cycles. Port 1 raises req in beat 2 -> 0x0002 on the cycle after port 5's done.
- req=0x201 with salu_prio_en=1 -> 0x0200 first, then 0x0001. With salu_prio_en=0 and rr_ptr=0 -> 0x0001 first.
- Port 7 with beats=2 drops req in beat 1 -> drop_err pulses, select=0, no grant_done[7].
- rst_n asserted mid-burst of port 4 -> select=0x0000 asynchronously. After release with req=0x010 -> a fresh grant with rr_ptr=0.
